// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access widths, FSM states
// and the alignment rule applied when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] DIGIT_WORD = 2'b00;
  localparam logic [1:0] DIGIT_HALF = 2'b01;
  localparam logic [1:0] DIGIT_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // Width 11 is illegal; word needs lane 0, half needs an even lane.
  function automatic logic access_ok(input logic [1:0] digit, input logic [1:0] lane);
    case (digit)
      DIGIT_WORD: access_ok = (lane == 2'b00);
      DIGIT_HALF: access_ok = ~lane[0];
      DIGIT_BYTE: access_ok = 1'b1;
      default:    access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Pipeline request/response and word-memory signals of the load/store unit.
// slave = the LSU itself; master = the pipeline/memory environment around it.
interface lsu_mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_digit;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_digit, req_sign, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_digit, req_sign, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: extracts/extends a load lane from a read word and
// merges store data into that lane. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  digit,
  input  logic        sign,
  input  logic [31:0] rd_dat,
  input  logic [15:0] st_dat,
  output logic [31:0] load_dat,
  output logic [31:0] merge_dat
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rd_dat[{lane, 3'b000} +: 8];
    half_sel  = rd_dat[{lane[1], 4'b0000} +: 16];
    load_dat  = rd_dat;
    merge_dat = rd_dat;
    case (digit)
      DIGIT_HALF: begin
        load_dat = {{16{sign & half_sel[15]}}, half_sel};
        merge_dat[{lane[1], 4'b0000} +: 16] = st_dat;
      end
      DIGIT_BYTE: begin
        load_dat = {{24{sign & byte_sel[7]}}, byte_sel};
        merge_dat[{lane, 3'b000} +: 8] = st_dat[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store unit against a word-only memory with req/ack handshake;
// sub-word stores are read-modify-write, waits are bounded by TIMEOUT cycles.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_mem_access_if.slave bus
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lane_q;
  logic [1:0]  digit_q;
  logic        sign_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic [31:0] load_dat;
  logic [31:0] merge_dat;

  lsu_lane_align u_align (
    .lane      (lane_q),
    .digit     (digit_q),
    .sign      (sign_q),
    .rd_dat    (bus.mem_rdata),
    .st_dat    (wdata_q),
    .load_dat  (load_dat),
    .merge_dat (merge_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= 8'd0;
      lane_q         <= 2'b00;
      digit_q        <= 2'b00;
      sign_q         <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= 16'd0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_err   <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            lane_q        <= bus.req_addr[1:0];
            digit_q       <= bus.req_digit;
            sign_q        <= bus.req_sign;
            we_q          <= bus.req_we;
            wdata_q       <= bus.req_wdata[15:0];
            if (!access_ok(bus.req_digit, bus.req_addr[1:0])) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'd0;
              state          <= RESP;
            end else begin
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              wait_cnt     <= 8'd0;
              if (bus.req_we && bus.req_digit == DIGIT_WORD) begin
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= bus.req_wdata;
                state         <= WR;
              end else begin
                // Loads and sub-word stores both start with a read.
                bus.mem_we <= 1'b0;
                state      <= RD;
              end
            end
          end
        end

        RD: begin
          if (bus.mem_ack) begin
            wait_cnt <= 8'd0;
            if (we_q) begin
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= merge_dat;
              state         <= WR;
            end else begin
              bus.mem_req    <= 1'b0;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_rdata <= load_dat;
              state          <= RESP;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            bus.mem_req    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'd0;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        WR: begin
          if (bus.mem_ack || wait_cnt == WAIT_LAST) begin
            // Ack arriving on the final wait cycle still counts as success.
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= ~bus.mem_ack;
            bus.resp_rdata <= 32'd0;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed plus random accesses checked against an arithmetic reference of the
// load/store rules, with the bench acting as a variable-latency word memory.
module tb_lsu_mem_access;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  lsu_mem_access_if #(.ADDR_W(32)) bus ();

  lsu_mem_access #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] waddr, input logic [31:0] val);
    mem[waddr]     = val;
    ref_mem[waddr] = val;
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] waddr);
    if (mem.exists(waddr)) return mem[waddr];
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] waddr);
    if (ref_mem.exists(waddr)) return ref_mem[waddr];
    return 32'd0;
  endfunction

  function automatic int unsigned acc_size(input logic [1:0] digit);
    case (digit)
      2'd0: return 4;
      2'd1: return 2;
      2'd2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [1:0] digit, input bit sign);
    int unsigned sh, v;
    if (digit == 2'd1) begin
      sh = 16 * ((addr / 2) % 2);
      v  = (word >> sh) & 32'hFFFF;
      if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else if (digit == 2'd2) begin
      sh = 8 * (addr % 4);
      v  = (word >> sh) & 32'hFF;
      if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] addr,
                                            input logic [1:0] digit, input logic [31:0] wdata);
    int unsigned sh, mask;
    if (digit == 2'd1) begin
      sh = 16 * ((addr / 2) % 2);
      mask = 32'hFFFF << sh;
      return (word & ~mask) | ((wdata & 32'hFFFF) << sh);
    end
    if (digit == 2'd2) begin
      sh = 8 * (addr % 4);
      mask = 32'hFF << sh;
      return (word & ~mask) | ((wdata & 32'hFF) << sh);
    end
    return wdata;
  endfunction

  // One complete access; delay = extra wait cycles before each ack.
  task automatic do_access(input string tag, input bit we, input logic [1:0] digit, input bit sign,
                           input logic [31:0] addr, input logic [31:0] wdata, input int delay);
    int unsigned size;
    bit illegal, tmo, sub;
    logic [31:0] waddr, old, exp_word, exp_rdata;
    int exp_req, exp_rd, exp_wr, exp_cyc, exp_err;
    int req_cycles, reads, writes, resp_cyc, n;
    bit got_resp, prev_req, prev_we, ack, addr_bad, wdata_bad;
    logic [31:0] rdata;
    logic err;

    size     = acc_size(digit);
    illegal  = (size == 0) || (addr % size != 0);
    tmo      = !illegal && (delay >= TMO);
    sub      = we && digit != 2'd0;
    waddr    = addr & 32'hFFFF_FFFC;
    old      = ref_word(waddr);
    exp_word = ref_merge(old, addr, digit, wdata);
    exp_rdata = 32'd0;
    exp_err  = 0;
    exp_rd   = 0;
    exp_wr   = 0;
    if (illegal) begin
      exp_req = 0; exp_cyc = 1; exp_err = 1;
    end else if (tmo) begin
      exp_req = TMO; exp_cyc = TMO + 1; exp_err = 1;
    end else if (!we) begin
      exp_req = delay + 1; exp_cyc = delay + 2; exp_rd = 1;
      exp_rdata = ref_load(old, addr, digit, sign);
    end else if (!sub) begin
      exp_req = delay + 1; exp_cyc = delay + 2; exp_wr = 1;
    end else begin
      exp_req = 2 * delay + 2; exp_cyc = 2 * delay + 3; exp_rd = 1; exp_wr = 1;
    end

    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_digit = digit;
    bus.req_sign  = sign;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);

    req_cycles = 0; reads = 0; writes = 0; resp_cyc = -1; n = 0;
    got_resp = 0; prev_req = 0; prev_we = 0; addr_bad = 0; wdata_bad = 0;
    rdata = 32'd0; err = 1'b0;
    for (int cyc = 1; cyc <= 60 && !got_resp; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.req_valid = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        got_resp = 1; resp_cyc = cyc; rdata = bus.resp_rdata; err = bus.resp_err;
      end
      if (bus.mem_req === 1'b1) begin
        req_cycles++;
        if (!prev_req || bus.mem_we !== prev_we) n = 1; else n++;
        if (bus.mem_addr !== waddr) addr_bad = 1;
        if (bus.mem_we === 1'b1 && bus.mem_wdata !== exp_word) wdata_bad = 1;
        ack = (n == delay + 1);
        bus.mem_ack = ack;
        bus.mem_rdata = $urandom;
        if (ack && bus.mem_we !== 1'b1) begin
          bus.mem_rdata = rd_word(waddr);
          reads++;
        end
        if (ack && bus.mem_we === 1'b1) begin
          mem[waddr] = bus.mem_wdata;
          writes++;
        end
        prev_req = 1;
        prev_we  = bus.mem_we;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        prev_req      = 0;
      end
    end

    check({tag, ".resp_cycle"}, 32'(resp_cyc), 32'(exp_cyc));
    check({tag, ".resp_err"},   32'(err),      32'(exp_err));
    check({tag, ".resp_rdata"}, rdata,         exp_rdata);
    check({tag, ".req_cycles"}, 32'(req_cycles), 32'(exp_req));
    check({tag, ".reads"},      32'(reads),    32'(exp_rd));
    check({tag, ".writes"},     32'(writes),   32'(exp_wr));
    check({tag, ".addr_stable"}, 32'(addr_bad), 32'd0);
    check({tag, ".wdata_stable"}, 32'(wdata_bad), 32'd0);
    @(negedge clk);
    check({tag, ".pulse"},      32'(bus.resp_valid), 32'd0);
    check({tag, ".rdata_hold"}, bus.resp_rdata, exp_rdata);
    if (we && !illegal && !tmo) ref_mem[waddr] = exp_word;
    check({tag, ".mem_word"},   rd_word(waddr), ref_word(waddr));
  endtask

  initial begin
    int resp_seen;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_digit = 2'd0; bus.req_sign = 1'b0;
    bus.req_addr  = 32'd0; bus.req_wdata = 32'd0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(bus.req_ready),  32'd0);
    check("rst.mem_req", 32'(bus.mem_req),  32'd0);
    check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;

    preload(32'h100, 32'h8899_AABB);
    do_access("lb_sx", 1'b0, 2'd2, 1'b1, 32'h101, 32'h0, 0);
    do_access("lb_zx", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0);
    preload(32'h200, 32'h1122_3344);
    do_access("sh_rmw", 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF, 0);
    do_access("sw_slow", 1'b1, 2'd0, 1'b0, 32'h204, 32'hDEAD_BEEF, 4);
    do_access("lw_mis", 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 0);
    do_access("lh_mis", 1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 0);
    do_access("dig11", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0);
    do_access("lw_tmo", 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 1000);
    do_access("lw_ack8", 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, TMO - 1);
    do_access("sb_tmo", 1'b1, 2'd2, 1'b0, 32'h201, 32'h55, 1000);
    do_access("sh_wr_ack8", 1'b1, 2'd1, 1'b0, 32'h200, 32'h1234, TMO - 1);

    // Reset while the write half of a byte store is outstanding.
    preload(32'h300, 32'h1122_3344);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_digit = 2'd2; bus.req_sign = 1'b0;
    bus.req_addr = 32'h301; bus.req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rst6.rd_req", 32'({bus.mem_req, bus.mem_we}), 32'd2);
    bus.mem_ack = 1'b1; bus.mem_rdata = rd_word(32'h300);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("rst6.wr_req", 32'({bus.mem_req, bus.mem_we}), 32'd3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst6.mem_req_drop", 32'(bus.mem_req), 32'd0);
    check("rst6.ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) resp_seen++;
    end
    check("rst6.no_resp", 32'(resp_seen), 32'd0);
    check("rst6.ready", 32'(bus.req_ready), 32'd1);
    check("rst6.mem_intact", rd_word(32'h300), 32'h1122_3344);
    do_access("rst6.lw_after", 1'b0, 2'd0, 1'b0, 32'h300, 32'h0, 1);

    for (int w = 0; w < 16; w++) preload(32'h400 + 32'(4 * w), $urandom);
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, wd;
      logic [1:0]  dg;
      int          dly;
      bit          we, sg;
      a   = 32'h400 + $urandom_range(0, 63);
      dg  = 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2));
      if ($urandom_range(0, 2) != 0) a = (dg == 2'd0) ? (a & ~32'd3) : (dg == 2'd1 ? (a & ~32'd1) : a);
      we  = bit'($urandom_range(0, 1));
      sg  = bit'($urandom_range(0, 1));
      wd  = $urandom;
      dly = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 3);
      do_access($sformatf("rnd%0d", k), we, dg, sg, a, wd, dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store access unit in the MEM stage of the pipelined CPU.
- Consumes the decoder's memory control signals: DataWr (store enable), Digit (access width) and Sign (load extension).
- Performs byte, half and word loads and stores against a word-only data memory that has a variable-latency req/ack handshake.
- Sub-word stores are done by read-modify-write. Aligns and extends load data. Reports misaligned and timed-out accesses.

Parameters:
- TIMEOUT, default 255: maximum cycles to wait for mem_ack before aborting (range 1..255).
- ADDR_W, default 32: byte address width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline access request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store (DataWr), 0 = load
- req_digit  in  2  access width: 00 = word, 01 = half, 10 = byte, 11 = illegal
- req_sign  in  1  1 = sign-extend load, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned, illegal width or timeout (valid with resp_valid)
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  full word to write
- mem_ack  in  1  memory completes on the rising edge where mem_req && mem_ack
- mem_rdata  in  32  read word, valid when mem_ack on a read

Behaviour:
- Reset: asynchronous, active-low.
  - State returns to IDLE. All outputs and registers go to 0: req_ready=0 during reset, 1 in IDLE after release.
  - Reset mid-transaction drops mem_req immediately; no response is ever issued for the aborted request.
- Handshake: a request is accepted on an edge with req_valid && req_ready. Address, width, sign, we and wdata are captured into registers. Inputs are ignored when not ready.
- Alignment check at acceptance:
  - Legal: word needs addr[1:0]==00; half needs addr[0]==0; byte is always legal.
  - Digit 11 or a misalignment goes to RESP with resp_err=1 and resp_rdata=0. No memory access is made.
- States: IDLE, RD, WR, RESP.
  - IDLE, accepted request:
    - load -> RD
    - word store -> WR
    - byte/half store -> RD (read phase of read-modify-write)
    - error -> RESP
  - RD: mem_req=1, mem_we=0. On ack: a load registers the extracted data and goes to RESP; a sub-word store registers the merged word and goes to WR.
  - WR: mem_req=1, mem_we=1, mem_wdata = stored word. On ack -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- mem_addr and mem_wdata are registered outputs and stay stable while mem_req=1.
- Zero-wait memory (ack in the first mem_req cycle). Request accepted at edge 0:
  - load or word store: resp_valid in cycle 2
  - sub-word store: resp_valid in cycle 3
  - error: resp_valid in cycle 1
- Lane selection is little-endian, using lane = addr[1:0].
  - byte: lane b covers bits [8b+7:8b]
  - half: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16]
- Load extension: req_sign=1 replicates the top bit of the lane; 0 fills with zeros. Word loads pass through unchanged.
- Store merge: replace only the selected lane of the read word with req_wdata[7:0] or [15:0]. Other bytes are preserved bit-exact.
- Timeout:
  - An 8-bit wait counter clears on entering RD or WR and increments each cycle with mem_req && !mem_ack.
  - When the counter reaches TIMEOUT without an ack: drop mem_req, go to RESP with resp_err=1 and resp_rdata=0. For a sub-word store the write is skipped.
  - Ack in the same cycle the counter reaches TIMEOUT counts as success (ack wins).
- resp_rdata holds its value until the next response; it is zero on store and error responses.

Decomposition:
- Shared package lsu_pkg holds:
  - width constants DIGIT_WORD=2'b00, DIGIT_HALF=2'b01, DIGIT_BYTE=2'b10
  - the state enum (IDLE/RD/WR/RESP)
- One natural combinational sub-module, lsu_lane_align:
  - given lane, digit, sign, read word and store data, produces the extended load value and the merged store word
  - shared by both datapaths and unit-testable alone

Test Plan:
1. Memory word at 0x100 = 0x8899AABB; lb at addr 0x101, sign=1, zero-wait ack -> resp_valid in cycle 2, resp_rdata=0xFFFFFFAA, resp_err=0. Same access with sign=0 -> 0x000000AA.
2. Memory word 0x11223344 at 0x200; sh at 0x202 with wdata=0x0000BEEF -> mem read, then mem write of 0xBEEF3344; resp_valid in cycle 3.
3. sw at 0x204 with wdata=0xDEADBEEF, ack delayed 4 cycles -> single write, mem_addr and mem_wdata stable throughout, resp_valid 1 cycle after ack, no read issued.
4. lw at 0x102, then lh at 0x103, then digit=11 -> each gives resp_err=1 and resp_rdata=0 in cycle 1, with mem_req never asserted.
5. TIMEOUT=8, mem_ack held low on an lw -> mem_req high for exactly 8 cycles, then resp_err=1. Repeat with ack on the 8th cycle -> success, resp_err=0.
6. Assert rst_n low during WR of an sb -> mem_req drops asynchronously; after release: IDLE, req_ready=1, no resp_valid; the next lw completes normally.
